// File: rtl/imo_resp_serializer.sv
// ---------------------------------------------------------------------------
// imo_resp_serializer
//
// Buffers 512-bit responses from the memory controller in a small circular
// FIFO and streams each entry out as eight 64-bit beats, least significant
// word first. The controller cannot be stalled, so a response that finds the
// FIFO full is dropped and recorded in the statistics.
//
// Ports
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   imo_resp_data  : 512-bit response payload
//   imo_resp_valid : one-cycle response strobe (no backpressure)
//   out_valid      : a beat is available
//   out_ready      : consumer accepts the current beat
//   out_data       : current 64-bit beat
//   out_idx        : beat index within the head entry (0..7)
//   out_last       : high on beat 7
//   flush          : discard all buffered data
//   clr_stat       : clear overflow / drop_cnt / resp_cnt
//   empty, full    : FIFO status from the registered count
//   overflow       : sticky, a response was dropped
//   drop_cnt       : dropped responses, saturating
//   resp_cnt       : accepted responses, wrapping
// ---------------------------------------------------------------------------
module imo_resp_serializer #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] imo_resp_data,
  input  logic         imo_resp_valid,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic [2:0]   out_idx,
  output logic         out_last,
  input  logic         flush,
  input  logic         clr_stat,
  output logic         empty,
  output logic         full,
  output logic         overflow,
  output logic [15:0]  drop_cnt,
  output logic [31:0]  resp_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  // Payload storage; no reset, only written on an accepted push.
  logic [511:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [2:0]    idx_q, idx_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [31:0]   resp_cnt_q, resp_cnt_d;

  logic [511:0]  head_entry;
  logic [63:0]   beat [8];

  logic hs;
  logic pop;
  logic push_req;
  logic accept;
  logic drop;

  assign head_entry = mem[rd_ptr_q];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_beat
      assign beat[gi] = head_entry[64*gi +: 64];
    end
  endgenerate

  // Status outputs are forced to their idle values while reset is held so
  // they are defined even before the first reset edge.
  assign out_valid = !rst && (count_q != '0);
  assign out_last  = !rst && (idx_q == 3'd7);
  assign empty     = rst || (count_q == '0);
  assign full      = !rst && (count_q == FULL_CNT);
  assign out_idx   = idx_q;
  assign out_data  = beat[idx_q];
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign resp_cnt  = resp_cnt_q;

  always_comb begin
    // A flush cycle swallows both the handshake and any incoming response.
    hs       = out_valid && out_ready && !flush;
    pop      = hs && (idx_q == 3'd7);
    push_req = imo_resp_valid && !flush && !rst;
    // A full FIFO still accepts when the head entry leaves on this edge.
    accept   = push_req && ((count_q != FULL_CNT) || pop);
    drop     = push_req && !accept;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    idx_d    = idx_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      idx_d    = '0;
    end else begin
      if (hs)     idx_d    = idx_q + 3'd1;
      if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
      case ({accept, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // An event in the same cycle as clr_stat survives the clear.
    if (clr_stat) begin
      overflow_d = drop;
      drop_cnt_d = drop ? 16'd1 : 16'd0;
      resp_cnt_d = accept ? 32'd1 : 32'd0;
    end else begin
      overflow_d = overflow_q || drop;
      drop_cnt_d = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
      resp_cnt_d = accept ? resp_cnt_q + 32'd1 : resp_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      resp_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      resp_cnt_q <= resp_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= imo_resp_data;
  end

endmodule

// File: tb/tb_imo_resp_serializer.sv
// ---------------------------------------------------------------------------
// tb_imo_resp_serializer
//
// Scoreboard bench. The stimulus side turns every accepted response into
// eight expected beats in a queue; a monitor on the falling edge compares the
// DUT's current beat and status against the queue and pops on each handshake.
// ---------------------------------------------------------------------------
module tb_imo_resp_serializer;

  localparam int DEPTH = 4;

  logic         clk;
  logic         rst;
  logic [511:0] imo_resp_data;
  logic         imo_resp_valid;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic [2:0]   out_idx;
  logic         out_last;
  logic         flush;
  logic         clr_stat;
  logic         empty;
  logic         full;
  logic         overflow;
  logic [15:0]  drop_cnt;
  logic [31:0]  resp_cnt;

  imo_resp_serializer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imo_resp_data  (imo_resp_data),
    .imo_resp_valid (imo_resp_valid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_idx        (out_idx),
    .out_last       (out_last),
    .flush          (flush),
    .clr_stat       (clr_stat),
    .empty          (empty),
    .full           (full),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt),
    .resp_cnt       (resp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [2:0]  idx;
  } beat_t;

  beat_t       exp_q [$];
  logic        m_ov;
  int unsigned m_dc;
  logic [31:0] m_rc;

  int checks;
  int errors;
  bit check_en;

  logic        prev_stall;
  logic [63:0] prev_data;
  logic [2:0]  prev_idx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int entries();
    return (exp_q.size() + 7) / 8;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: current DUT state versus the reference model.
  always @(negedge clk) begin
    if (check_en) begin
      logic exp_v;
      exp_v = !rst && (exp_q.size() != 0);
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
      chk("empty", {63'd0, empty}, {63'd0, rst || (entries() == 0)});
      chk("full", {63'd0, full}, {63'd0, !rst && (entries() == DEPTH)});
      chk("overflow", {63'd0, overflow}, {63'd0, m_ov});
      chk("drop_cnt", {48'd0, drop_cnt}, 64'(m_dc));
      chk("resp_cnt", {32'd0, resp_cnt}, {32'd0, m_rc});
      if (prev_stall) begin
        chk("stall_data", out_data, prev_data);
        chk("stall_idx", {61'd0, out_idx}, {61'd0, prev_idx});
      end
      if (exp_v) begin
        chk("out_data", out_data, exp_q[0].d);
        chk("out_idx", {61'd0, out_idx}, {61'd0, exp_q[0].idx});
        chk("out_last", {63'd0, out_last}, {63'd0, exp_q[0].idx == 3'd7});
        if (out_ready && !flush) begin
          $display("beat idx=%0d data=%016h", exp_q[0].idx, exp_q[0].d);
          void'(exp_q.pop_front());
        end
      end else begin
        chk("out_last_idle", {63'd0, out_last}, 64'd0);
      end
      prev_stall = exp_v && !out_ready && !flush;
      prev_data  = out_data;
      prev_idx   = out_idx;
    end
  end

  // One clock of stimulus; the model is updated after the monitor has popped
  // any beat consumed on the coming edge.
  task automatic step(input logic v, input logic [511:0] d, input logic rdy,
                      input logic fl, input logic cs, input logic r);
    bit acc, drp;
    @(posedge clk);
    #1;
    imo_resp_valid = v;
    imo_resp_data  = d;
    out_ready      = rdy;
    flush          = fl;
    clr_stat       = cs;
    rst            = r;
    @(negedge clk);
    #1;
    acc = 1'b0;
    drp = 1'b0;
    if (r) begin
      exp_q.delete();
      m_ov = 1'b0;
      m_dc = 0;
      m_rc = '0;
    end else begin
      if (fl) exp_q.delete();
      else if (v) begin
        // Entry count after this edge's pop decides acceptance.
        if (entries() < DEPTH) acc = 1'b1;
        else drp = 1'b1;
      end
      if (acc) begin
        for (int k = 0; k < 8; k++) exp_q.push_back('{d[64*k +: 64], 3'(k)});
      end
      if (cs) begin
        m_ov = drp;
        m_dc = drp ? 1 : 0;
        m_rc = acc ? 32'd1 : 32'd0;
      end else begin
        if (drp) begin
          m_ov = 1'b1;
          if (m_dc < 32'hFFFF) m_dc++;
        end
        if (acc) m_rc++;
      end
    end
    if (v) $display("resp strobe acc=%0d drop=%0d flush=%0d rst=%0d", acc, drp, fl, r);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, rdy, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic rdy);
    step(1'b1, rand512(), rdy, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (8 * DEPTH + 4) idle(1'b1);
  endtask

  initial begin
    logic [511:0] pat;
    logic [15:0]  saved_dc;
    logic [31:0]  saved_rc;

    checks = 0;
    errors = 0;
    check_en = 1'b0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_idx = '0;
    m_ov = 1'b0;
    m_dc = 0;
    m_rc = '0;
    rst = 1'b1;
    imo_resp_valid = 1'b0;
    imo_resp_data = '0;
    out_ready = 1'b0;
    flush = 1'b0;
    clr_stat = 1'b0;

    // Reset, with a strobe that must be ignored.
    step(1'b1, rand512(), 1'b1, 1'b0, 1'b0, 1'b1);
    check_en = 1'b1;
    chk("reset_empty", {63'd0, empty}, 64'd1);
    chk("reset_full", {63'd0, full}, 64'd0);
    chk("reset_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_resp_cnt", {32'd0, resp_cnt}, 64'd0);
    idle(1'b0);

    // Single response with a recognisable pattern, ready held high.
    for (int k = 0; k < 8; k++) pat[64*k +: 64] = 64'h1111_0000_0000_0000 * 64'(k) + 64'(k);
    step(1'b1, pat, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (9) idle(1'b1);
    chk("single_empty", {63'd0, empty}, 64'd1);
    chk("single_resp_cnt", {32'd0, resp_cnt}, 64'd1);

    // Backpressure with ready pattern 1,0,0,1,...
    push(1'b0);
    push(1'b0);
    for (int i = 0; i < 60; i++) idle((i % 3) == 0);
    drain();

    // Overflow: DEPTH+2 strobes with no consumer.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (DEPTH + 2) push(1'b0);
    idle(1'b0);
    chk("ovf_full", {63'd0, full}, 64'd1);
    chk("ovf_flag", {63'd0, overflow}, 64'd1);
    chk("ovf_drop_cnt", {48'd0, drop_cnt}, 64'd2);
    chk("ovf_resp_cnt", {32'd0, resp_cnt}, 64'(DEPTH));
    drain();

    // Full FIFO, strobe on the beat-7 handshake.
    repeat (DEPTH) push(1'b0);
    saved_dc = drop_cnt;
    repeat (7) idle(1'b1);
    push(1'b1);
    idle(1'b0);
    chk("fullpop_full", {63'd0, full}, 64'd1);
    chk("fullpop_drop_cnt", {48'd0, drop_cnt}, {48'd0, saved_dc});
    drain();

    // Flush mid-entry with a strobe, then clear together with a drop.
    push(1'b0);
    push(1'b0);
    repeat (3) idle(1'b1);
    saved_dc = drop_cnt;
    saved_rc = resp_cnt;
    step(1'b1, rand512(), 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    chk("flush_empty", {63'd0, empty}, 64'd1);
    chk("flush_idx", {61'd0, out_idx}, 64'd0);
    chk("flush_drop_cnt", {48'd0, drop_cnt}, {48'd0, saved_dc});
    chk("flush_resp_cnt", {32'd0, resp_cnt}, {32'd0, saved_rc});
    repeat (DEPTH) push(1'b0);
    step(1'b1, rand512(), 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    chk("clr_overflow", {63'd0, overflow}, 64'd1);
    chk("clr_drop_cnt", {48'd0, drop_cnt}, 64'd1);
    drain();

    // Reset mid-operation at out_idx=5 with two entries buffered.
    push(1'b0);
    push(1'b0);
    repeat (5) idle(1'b1);
    step(1'b1, rand512(), 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_idx", {61'd0, out_idx}, 64'd0);
    chk("rst_resp_cnt", {32'd0, resp_cnt}, 64'd0);
    idle(1'b1);
    push(1'b1);
    drain();

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 40), rand512(), ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 1));
    end
    drain();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imo_resp_serializer.md
IMO_RESP_SERIALIZER -- requirements
Module: imo_resp_serializer

Interface
- REQ-001: The block SHALL use one clock and a synchronous, active-high reset.
- REQ-002: DEPTH, default 4, SHALL set the number of 512-bit response entries buffered; it SHALL be a power of two, at least 2.
- REQ-003: clk  input  1  clock; all logic SHALL be rising-edge.
- REQ-004: rst  input  1  synchronous active-high reset.
- REQ-005: imo_resp_data  input  512  response payload from the memory controller.
- REQ-006: imo_resp_valid  input  1  one-cycle strobe; there is no backpressure toward the controller.
- REQ-007: out_valid  output  1  a beat is available.
- REQ-008: out_ready  input  1  consumer accepts the beat.
- REQ-009: out_data  output  64  current beat.
- REQ-010: out_idx  output  3  beat index within the entry, 0..7.
- REQ-011: out_last  output  1  high when out_idx==7.
- REQ-012: flush  input  1  discard all buffered data.
- REQ-013: clr_stat  input  1  clear the statistics.
- REQ-014: empty, full  output  1 each  FIFO status from the registered count.
- REQ-015: overflow  output  1  sticky flag: a response was dropped.
- REQ-016: drop_cnt  output  16  dropped responses, saturating at 16'hFFFF.
- REQ-017: resp_cnt  output  32  accepted responses, wrapping.

Function
- REQ-018: Storage SHALL be a DEPTH x 512 circular FIFO with write pointer, read pointer and count (width log2(DEPTH)+1); both pointers SHALL wrap modulo DEPTH.
- REQ-019: out_valid SHALL equal (count != 0); out_data SHALL equal head_entry[64*out_idx +: 64].
- REQ-020: Beat order SHALL be bits [63:0] first and bits [511:448] last.
- REQ-021: A beat handshake (out_valid && out_ready) SHALL advance out_idx by 1.
- REQ-022: On the handshake with out_idx==7, out_idx SHALL return to 0, the read pointer SHALL advance and count SHALL decrement (pop).
- REQ-023: out_idx and out_data SHALL stay stable while out_valid is high and out_ready is low.
- REQ-024: Latency: a response strobed into an empty FIFO at edge N SHALL give out_valid=1 with out_idx=0 in the cycle after edge N.
- REQ-025: A push SHALL be accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle; in the second case count stays DEPTH.
- REQ-026: A simultaneous push and pop at any count SHALL leave count unchanged.
- REQ-027: Each accepted push SHALL increment resp_cnt.
- REQ-028: A push that is not accepted SHALL discard the data, set overflow and increment drop_cnt (saturating).
- REQ-029: full SHALL equal (count==DEPTH); empty SHALL equal (count==0).
- REQ-030: flush SHALL zero the pointers, count and out_idx on the next edge.
- REQ-031: A push coinciding with flush SHALL be discarded without counting as a drop or an accept; a beat handshake in the same cycle SHALL be ignored.
- REQ-032: clr_stat SHALL zero overflow, drop_cnt and resp_cnt on the next edge.
- REQ-033: If a drop or an accept coincides with clr_stat, the event SHALL win: overflow=1 and drop_cnt=1, or resp_cnt=1, respectively.
- REQ-034: flush and clr_stat SHALL be independent; neither SHALL affect the state the other controls.
- REQ-035: Payload RAM SHALL need no reset; only control and status state is reset.

Reset
- REQ-036: While rst is high, pointers, count, out_idx, overflow, drop_cnt and resp_cnt SHALL become 0 on each edge.
- REQ-037: While rst is high, out_valid=0, out_last=0, empty=1 and full=0.
- REQ-038: Reset mid-transfer SHALL abandon the partially sent entry; after reset, out_valid stays 0 until a new response is strobed.
- REQ-039: imo_resp_valid during reset SHALL be ignored and not counted.

Verification
- REQ-040: Single response, out_ready held high: data with word k = 64'h1111_0000_0000_0000*k+k (k=0..7) -> 8 consecutive beats, out_idx 0..7, out_last only on beat 7, out_data equal to word k; then empty=1 and resp_cnt=1.
- REQ-041: Backpressure: out_ready toggled 1,0,0,1,... -> out_data/out_idx stable during stalls; no beat lost or repeated.
- REQ-042: Overflow: DEPTH+2 strobes with out_ready=0 -> full=1, overflow=1, drop_cnt=2, resp_cnt=DEPTH; draining yields the first DEPTH entries in order.
- REQ-043: Full with simultaneous pop: FIFO full, strobe on the same cycle as the beat-7 handshake -> accepted, count stays DEPTH, drop_cnt unchanged.
- REQ-044: Flush and clear: flush mid-entry at out_idx=3 together with a strobe -> next cycle empty=1, out_idx=0, counters unchanged; then clr_stat together with a drop -> overflow=1, drop_cnt=1.
- REQ-045: Reset mid-operation: rst asserted with 2 entries buffered at out_idx=5 -> all outputs reach reset values the next cycle; a new strobe after reset streams from out_idx=0.
